sample_fifo_ctrl: RTL and testbench
===================================

SAMPLE_FIFO_CTRL -- requirements
Module: sample_fifo_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, bit-width of sample data.
REQ-002 Parameter DEPTHBIT, default 4, FIFO depth = 2^DEPTHBIT entries.
REQ-003 Parameter AFULL_LVL, default 12, level at or above which almost_full asserts.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 clr  input  1  synchronous flush; empties the FIFO.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 rd_en  input  1  read request (pop).
REQ-010 rd_data  output  WIDTH  head-of-FIFO data, first-word-fall-through.
REQ-011 empty  output  1  no entries stored.
REQ-012 full  output  1  2^DEPTHBIT entries stored.
REQ-013 almost_full  output  1  level >= AFULL_LVL.
REQ-014 level  output  DEPTHBIT+1  current entry count.
REQ-015 overflow  output  1  sticky: write attempted while full.
REQ-016 underflow  output  1  sticky: read attempted while empty.

Function
REQ-017 Write accepted when wr_en=1 and full=0; stores wr_data at wr_ptr and increments wr_ptr on that edge.
REQ-018 Read accepted when rd_en=1 and empty=0; increments rd_ptr on that edge.
REQ-019 rd_data equals the entry at rd_ptr combinationally; valid only while empty=0, don't-care otherwise.
REQ-020 Data written at edge N appears on rd_data after edge N when FIFO was empty; empty deasserts after edge N.
REQ-021 Pointers are DEPTHBIT+1 bits wide; RAM address = low DEPTHBIT bits; wrap from 2^DEPTHBIT-1 to 0 is natural rollover.
REQ-022 empty = (wr_ptr == rd_ptr); full = low bits equal and MSBs differ.
REQ-023 level = wr_ptr - rd_ptr modulo 2^(DEPTHBIT+1); range 0..2^DEPTHBIT.
REQ-024 Simultaneous accepted read and write: level unchanged, both pointers advance.
REQ-025 wr_en while full: write rejected (even if rd_en=1 in the same cycle), no state change except overflow set.
REQ-026 rd_en while empty: read rejected (even if wr_en=1 in the same cycle), underflow set; the write proceeds.
REQ-027 overflow/underflow stay set until clr or reset.
REQ-028 clr=1: pointers to 0, overflow/underflow to 0 on that edge; wr_en/rd_en in the same cycle ignored.
REQ-029 Storage RAM write port driven only on port A (we_a = accepted write); port B used for read only with we_b tied 0, so the RAM's both-write-enables inhibit never triggers.

Reset
REQ-030 rst_n=0 immediately forces wr_ptr=0, rd_ptr=0, overflow=0, underflow=0; hence empty=1, full=0, almost_full=0, level=0.
REQ-031 RAM contents are not reset; rd_data is undefined after reset until the first write.
REQ-032 Reset asserted mid-transfer discards all stored entries; no write completes on the edge coinciding with reset.

Structure
REQ-033 No shared package; WIDTH, DEPTHBIT, AFULL_LVL are module parameters passed through from the instantiating level.
REQ-034 One sub-module: dual_port_ram (WIDTH, DEPTHBIT), clk_a and clk_b both tied to clk.
REQ-035 Pointer/flag logic in this module only; no additional register stage on rd_data.

Verification (WIDTH=8, DEPTHBIT=4, AFULL_LVL=12)
REQ-036 Reset, write 0x11, 0x22, 0x33, then read 3 -> rd_data 0x11, 0x22, 0x33 in order; empty=1 after 3rd pop, level 3->0.
REQ-037 Write 16 entries 0x00..0x0F -> almost_full=1 at level 12, full=1 at 16; 17th write 0xFF rejected, overflow=1, readback 0x00..0x0F.
REQ-038 rd_en on empty FIFO with wr_en=1, wr_data=0xA5 -> underflow=1, level=1, rd_data=0xA5 next cycle.
REQ-039 Fill 8, then 40 cycles of simultaneous rd_en/wr_en incrementing data -> level stays 8, pointers wrap, ordering preserved.
REQ-040 Level 5, assert clr with wr_en=1 -> level=0, empty=1, flags cleared, write discarded.
REQ-041 Level 10, pulse rst_n low between edges -> empty=1, level=0 immediately, before next clk edge.

Source files
------------

// File: rtl/dual_port_ram.sv
// Two-port storage array: ports A and B can each write, and port B reads combinationally.
// If both ports request a write in the same cycle, neither write takes effect.
module dual_port_ram #(
  parameter int WIDTH    = 8,
  parameter int DEPTHBIT = 4
) (
  input  logic                clk_a,
  input  logic                we_a,
  input  logic [DEPTHBIT-1:0] addr_a,
  input  logic [WIDTH-1:0]    din_a,
  input  logic                clk_b,
  input  logic                we_b,
  input  logic [DEPTHBIT-1:0] addr_b,
  input  logic [WIDTH-1:0]    din_b,
  output logic [WIDTH-1:0]    dout_b
);

  logic [WIDTH-1:0] mem [2**DEPTHBIT];

  // Both port clocks are the same net in every instantiation, so a single
  // write process keeps the array singly driven.
  logic unused_clk_b;
  assign unused_clk_b = clk_b;

  always_ff @(posedge clk_a) begin
    if (we_a && !we_b) begin
      mem[addr_a] <= din_a;
    end else if (we_b && !we_a) begin
      mem[addr_b] <= din_b;
    end
  end

  assign dout_b = mem[addr_b];

endmodule

// File: rtl/sample_fifo_ctrl.sv
// Single-clock first-word-fall-through sample FIFO. Occupancy is tracked with
// DEPTHBIT+1-bit pointers, and overflow and underflow are recorded in sticky flags.
module sample_fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTHBIT  = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic                empty,
  output logic                full,
  output logic                almost_full,
  output logic [DEPTHBIT:0]   level,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [DEPTHBIT:0] PTR_ONE  = 1;
  localparam logic [DEPTHBIT:0] AFULL_TH = AFULL_LVL[DEPTHBIT:0];

  logic [DEPTHBIT:0] wr_ptr;
  logic [DEPTHBIT:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Handshake: a write is taken on an edge where wr_en=1 and full=0, and a pop is
  // taken on an edge where rd_en=1 and empty=0. A request against the wrong
  // occupancy is dropped and sets its sticky flag, and clr overrides both requests.
  assign wr_acc = wr_en && !full  && !clr;
  assign rd_acc = rd_en && !empty && !clr;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[DEPTHBIT-1:0] == rd_ptr[DEPTHBIT-1:0]) &&
                       (wr_ptr[DEPTHBIT] != rd_ptr[DEPTHBIT]);
  assign level       = wr_ptr - rd_ptr;
  assign almost_full = (level >= AFULL_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  // Port B only reads. Because port B never writes, the RAM's two-writer inhibit cannot fire.
  dual_port_ram #(
    .WIDTH    (WIDTH),
    .DEPTHBIT (DEPTHBIT)
  ) u_ram (
    .clk_a  (clk),
    .we_a   (wr_acc),
    .addr_a (wr_ptr[DEPTHBIT-1:0]),
    .din_a  (wr_data),
    .clk_b  (clk),
    .we_b   (1'b0),
    .addr_b (rd_ptr[DEPTHBIT-1:0]),
    .din_b  ('0),
    .dout_b (rd_data)
  );

endmodule

// File: tb/tb_sample_fifo_ctrl.sv
// Bench for sample_fifo_ctrl. Directed scenarios are followed by randomized traffic,
// and every cycle is checked against a queue-based model of the FIFO.
module tb_sample_fifo_ctrl;

  localparam int W     = 8;
  localparam int DB    = 4;
  localparam int AF    = 12;
  localparam int DEPTH = 1 << DB;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [DB:0]   level;
  logic          overflow;
  logic          underflow;

  sample_fifo_ctrl #(.WIDTH(W), .DEPTHBIT(DB), .AFULL_LVL(AF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         exp_ovf;
  logic         exp_udf;
  int           n_cmp;
  int           n_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = exp_q.size();
    check_val({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check_val({tag, ".full"},  32'(full),  32'(n == DEPTH));
    check_val({tag, ".afull"}, 32'(almost_full), 32'(n >= AF));
    check_val({tag, ".level"}, 32'(level), 32'(n));
    check_val({tag, ".ovf"},   32'(overflow),  32'(exp_ovf));
    check_val({tag, ".udf"},   32'(underflow), 32'(exp_udf));
    if (n != 0) check_val({tag, ".rd_data"}, 32'(rd_data), 32'(exp_q[0]));
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask

  // driver: called just after a falling edge; applies the inputs for one clock,
  // updates the model at the rising edge, and checks 1 ns later
  task automatic cycle(input string tag, input logic w, input logic [W-1:0] d,
                       input logic r, input logic c);
    logic was_full;
    logic was_empty;
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(posedge clk);
    if (c) begin
      model_clear();
    end else begin
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      if (w && was_full)  exp_ovf = 1'b1;
      if (r && was_empty) exp_udf = 1'b1;
      if (r && !was_empty) void'(exp_q.pop_front());
      if (w && !was_full)  exp_q.push_back(d);
    end
    #1;
    check_all(tag);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_clear();
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // three writes and three reads, checked in order
    cycle("w3", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("w3", 1'b1, 8'h22, 1'b0, 1'b0);
    cycle("w3", 1'b1, 8'h33, 1'b0, 1'b0);
    check_val("w3.level3", 32'(level), 32'd3);
    check_val("r3.head", 32'(rd_data), 32'h11);
    cycle("r3", 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("r3.head2", 32'(rd_data), 32'h22);
    cycle("r3", 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("r3.head3", 32'(rd_data), 32'h33);
    cycle("r3", 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("r3.empty", 32'(empty), 32'd1);

    // fill to 16, attempt a 17th write, then drain
    for (int i = 0; i < DEPTH; i++) begin
      cycle("fill", 1'b1, W'(i), 1'b0, 1'b0);
      if (i == AF - 1) check_val("fill.afull12", 32'(almost_full), 32'd1);
    end
    check_val("fill.full16", 32'(full), 32'd1);
    cycle("ovf", 1'b1, 8'hFF, 1'b0, 1'b0);
    check_val("ovf.flag", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check_val("drain.data", 32'(rd_data), 32'(i));
      cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check_val("drain.ovf_sticky", 32'(overflow), 32'd1);

    // read while empty, with a simultaneous write
    cycle("clr0", 1'b0, 8'h00, 1'b0, 1'b1);
    cycle("udf", 1'b1, 8'hA5, 1'b1, 1'b0);
    check_val("udf.flag", 32'(underflow), 32'd1);
    check_val("udf.level", 32'(level), 32'd1);
    check_val("udf.data", 32'(rd_data), 32'hA5);
    cycle("udf.pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // fill to 8, then 40 cycles of simultaneous read and write
    for (int i = 0; i < 8; i++) cycle("f8", 1'b1, W'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle("stream", 1'b1, W'(8'h48 + i), 1'b1, 1'b0);
      check_val("stream.level8", 32'(level), 32'd8);
    end

    // clr with a write in the same cycle
    cycle("clr1", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle("l5", 1'b1, W'(8'h60 + i), 1'b0, 1'b0);
    cycle("clrw", 1'b1, 8'h77, 1'b0, 1'b1);
    check_val("clrw.level", 32'(level), 32'd0);

    // asynchronous reset pulsed between edges at level 10
    for (int i = 0; i < 10; i++) cycle("l10", 1'b1, W'(8'h80 + i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all("arst");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("arst.post");

    // randomized traffic; phases alternate write-heavy and read-heavy
    for (int p = 0; p < 12; p++) begin
      int wp;
      wp = (p % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 50; i++) begin
        cycle("rnd",
              $urandom_range(0, 99) < wp,
              W'($urandom_range(0, 255)),
              $urandom_range(0, 99) < (100 - wp),
              $urandom_range(0, 199) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
